// File: rtl/round_state_collector.sv
// Collects four column words from the add-round-key stage into one AES state
// and hands it downstream with its round index, holding it until accepted.
module round_state_collector #(
  parameter int WORD_DATA_WIDTH  = 32,
  parameter int STATE_DATA_WIDTH = 4 * WORD_DATA_WIDTH,
  parameter int LAST_ROUND       = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WORD_DATA_WIDTH-1:0]  word_in,
  input  logic                        word_in_vld,
  output logic                        word_in_rdy,
  input  logic                        flush,
  output logic [STATE_DATA_WIDTH-1:0] state_out,
  output logic                        state_out_vld,
  input  logic                        state_out_rdy,
  output logic [3:0]                  state_out_rnd,
  output logic                        state_out_last
);

  localparam int W = WORD_DATA_WIDTH;
  localparam logic [3:0] LAST_RND = 4'(LAST_ROUND);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t     state;
  logic [1:0] word_cnt;

  // Gated by rst_n so nothing is offered upstream while reset is held.
  assign word_in_rdy = rst_n && (state == COLLECT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= COLLECT;
      word_cnt       <= 2'd0;
      state_out      <= '0;
      state_out_vld  <= 1'b0;
      state_out_rnd  <= 4'd0;
      state_out_last <= 1'b0;
    end else if (flush) begin
      state          <= COLLECT;
      word_cnt       <= 2'd0;
      state_out_vld  <= 1'b0;
      state_out_rnd  <= 4'd0;
      state_out_last <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (word_in_vld) begin
            case (word_cnt)
              2'd0:    state_out[4*W-1 -: W] <= word_in;
              2'd1:    state_out[3*W-1 -: W] <= word_in;
              2'd2:    state_out[2*W-1 -: W] <= word_in;
              default: state_out[W-1 -: W]   <= word_in;
            endcase
            word_cnt <= word_cnt + 2'd1;
            if (word_cnt == 2'd3) begin
              state          <= HOLD;
              state_out_vld  <= 1'b1;
              state_out_last <= (state_out_rnd == LAST_RND);
            end
          end
        end
        HOLD: begin
          // Input stays blocked in this cycle even when the state is taken.
          if (state_out_rdy) begin
            state          <= COLLECT;
            state_out_vld  <= 1'b0;
            state_out_last <= 1'b0;
            state_out_rnd  <= (state_out_rnd == LAST_RND) ? 4'd0 : state_out_rnd + 4'd1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_round_state_collector.sv
// Scoreboard bench for round_state_collector: directed scenarios plus random
// traffic, checked against a queue-based model of the collector.
module tb_round_state_collector;

  localparam int LAST = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  word_in = '0;
  logic         word_in_vld = 1'b0;
  logic         word_in_rdy;
  logic         flush = 1'b0;
  logic [127:0] state_out;
  logic         state_out_vld;
  logic         state_out_rdy = 1'b0;
  logic [3:0]   state_out_rnd;
  logic         state_out_last;

  typedef struct packed {
    logic [127:0] st;
    logic [3:0]   rnd;
    logic         last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_words[$];
  bit          m_hold = 0;
  int          m_round = 0;
  int          total = 0;
  int          bad = 0;

  round_state_collector #(
    .WORD_DATA_WIDTH(32),
    .STATE_DATA_WIDTH(128),
    .LAST_ROUND(LAST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .word_in(word_in),
    .word_in_vld(word_in_vld),
    .word_in_rdy(word_in_rdy),
    .flush(flush),
    .state_out(state_out),
    .state_out_vld(state_out_vld),
    .state_out_rdy(state_out_rdy),
    .state_out_rnd(state_out_rnd),
    .state_out_last(state_out_last)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs and advances the model to the state the
  // collector should be in after the coming rising edge.
  task automatic applyStimulus(input bit r, input bit f, input bit v,
                               input logic [31:0] w, input bit ordy);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    flush = f;
    word_in_vld = v;
    word_in = w;
    state_out_rdy = ordy;
    if (!r) begin
      m_hold = 0;
      m_words.delete();
      m_round = 0;
    end else if (f) begin
      m_hold = 0;
      m_words.delete();
      m_round = 0;
    end else if (!m_hold) begin
      if (v) begin
        m_words.push_back(w);
        if (m_words.size() == 4) begin
          e.st = {m_words[0], m_words[1], m_words[2], m_words[3]};
          e.rnd = 4'(m_round);
          e.last = (m_round == LAST);
          sb.push_back(e);
          m_words.delete();
          m_hold = 1;
        end
      end
    end else if (ordy) begin
      m_hold = 0;
      m_round = (m_round == LAST) ? 0 : m_round + 1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fullBlock(input logic [31:0] base, input bit ordy);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 1, base + 32'(i), ordy);
    applyStimulus(1, 0, 0, 32'h0, ordy);
  endtask

  // Monitor: pops the scoreboard when a new valid state appears and checks
  // the handshake/round outputs against the model every cycle.
  initial begin : monitor
    bit   prev_vld = 0;
    exp_t cur = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        checkOutput("reset_state", state_out, 128'h0);
        checkOutput("reset_vld", {127'h0, state_out_vld}, 128'h0);
      end
      checkOutput("word_in_rdy", {127'h0, word_in_rdy}, {127'h0, (rst_n && !m_hold)});
      checkOutput("vld", {127'h0, state_out_vld}, {127'h0, m_hold});
      checkOutput("rnd", {124'h0, state_out_rnd}, 128'(m_round));
      checkOutput("last", {127'h0, state_out_last}, {127'h0, (m_hold && m_round == LAST)});
      if (state_out_vld && !prev_vld) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("[TB] FAIL sb_underflow actual=valid required=no_output at %0t", $time);
        end else begin
          cur = sb.pop_front();
        end
      end
      if (state_out_vld) begin
        checkOutput("state", state_out, cur.st);
        checkOutput("state_rnd", {124'h0, state_out_rnd}, {124'h0, cur.rnd});
        checkOutput("state_last", {127'h0, state_out_last}, {127'h0, cur.last});
      end
      prev_vld = state_out_vld;
    end
  end

  initial begin : stimulus
    applyStimulus(0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0);

    // Known-answer block, then back-pressure with ignored input words.
    applyStimulus(1, 0, 1, 32'h00112233, 0);
    applyStimulus(1, 0, 1, 32'h44556677, 0);
    applyStimulus(1, 0, 1, 32'h8899AABB, 0);
    applyStimulus(1, 0, 1, 32'hCCDDEEFF, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 32'hDEADBEEF, 0);
    #2;
    checkOutput("kat_state", state_out, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    applyStimulus(1, 0, 0, 32'h0, 1);
    applyStimulus(1, 0, 0, 32'h0, 1);
    #2;
    checkOutput("kat_rnd_after", {124'h0, state_out_rnd}, 128'd1);

    // Twelve back-to-back blocks from round 0 to see the wrap.
    applyStimulus(0, 0, 0, 32'h0, 0);
    for (int b = 0; b < 12; b++) fullBlock(32'h1000_0000 + 32'(b << 8), 1);

    // Flush mid-block at round 3.
    applyStimulus(0, 0, 0, 32'h0, 0);
    for (int b = 0; b < 3; b++) fullBlock(32'h2000_0000 + 32'(b << 8), 1);
    applyStimulus(1, 0, 1, 32'hAAAA0001, 0);
    applyStimulus(1, 0, 1, 32'hAAAA0002, 0);
    applyStimulus(1, 1, 1, 32'hAAAA0003, 0);
    fullBlock(32'hBBBB0000, 0);
    #2;
    checkOutput("flush_state", state_out, 128'hBBBB0000_BBBB0001_BBBB0002_BBBB0003);
    applyStimulus(1, 0, 0, 32'h0, 1);

    // Reset while holding a round-5 state.
    applyStimulus(0, 0, 0, 32'h0, 0);
    for (int b = 0; b < 5; b++) fullBlock(32'h3000_0000 + 32'(b << 8), 1);
    fullBlock(32'h3333_0000, 0);
    applyStimulus(0, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 0);

    // Gapped input over eight cycles.
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 0, (i % 2) == 0, 32'h4444_0000 + 32'(i), 0);
    applyStimulus(1, 0, 0, 32'h0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(99) != 0, $urandom_range(49) == 0,
                    $urandom_range(9) < 7, $urandom, $urandom_range(1) == 1);

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 32'h0, 1);
    @(posedge clk);
    #2;
    checkOutput("sb_drained", 128'(sb.size()), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_state_collector.md
ROUND_STATE_COLLECTOR -- requirements
Module: round_state_collector

Interface
REQ-001 The block SHALL have parameter WORD_DATA_WIDTH, default 32 (`WORD_DATA_WIDTH), the width of one state column word.
REQ-002 The block SHALL have parameter STATE_DATA_WIDTH, default 4*WORD_DATA_WIDTH (128), the width of one full AES state.
REQ-003 The block SHALL have parameter LAST_ROUND, default 10, the highest round index before wrap.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset: synchronous, active-low, sampled on the rising edge of clk.
REQ-006 word_in  input  WORD_DATA_WIDTH  column word from the add-round-key stage.
REQ-007 word_in_vld  input  1  word_in carries a valid column.
REQ-008 word_in_rdy  output  1  collector can accept a word this cycle.
REQ-009 flush  input  1  abort the current block; clear word and round counters.
REQ-010 state_out  output  STATE_DATA_WIDTH  assembled state; column 0 in [127:96], column 3 in [31:0].
REQ-011 state_out_vld  output  1  state_out holds a complete 4-word state.
REQ-012 state_out_rdy  input  1  downstream accepts state_out this cycle.
REQ-013 state_out_rnd  output  4  round index of the state on state_out (0..LAST_ROUND).
REQ-014 state_out_last  output  1  high with state_out_vld when state_out_rnd == LAST_ROUND.

Function
REQ-015 The FSM SHALL have two states: COLLECT and HOLD.
REQ-016 In COLLECT, word_in_rdy SHALL be 1; in HOLD, word_in_rdy SHALL be 0; word_in_rdy SHALL be 0 while rst_n is low.
REQ-017 A word is accepted only when word_in_vld && word_in_rdy; word_in_vld while word_in_rdy is 0 SHALL be ignored, no capture.
REQ-018 A 2-bit word counter (0..3) SHALL select the column written: count 0 -> [127:96], 1 -> [95:64], 2 -> [63:32], 3 -> [31:0]; it increments by one per accepted word.
REQ-019 On the 4th accepted word (count 3): counter wraps to 0, FSM goes to HOLD, state_out_vld = 1 from the next cycle (1-cycle latency from last word to valid).
REQ-020 In HOLD, state_out, state_out_rnd and state_out_last SHALL remain stable until state_out_rdy is sampled high.
REQ-021 HOLD with state_out_rdy = 1: next cycle state_out_vld = 0, FSM to COLLECT, round counter +1; at LAST_ROUND it wraps to 0 instead.
REQ-022 No bypass: in the HOLD cycle that state_out_rdy is accepted, word_in_rdy SHALL still be 0; earliest next accepted word is one cycle later.
REQ-023 state_out SHALL keep its last contents in COLLECT; partially written columns are visible but not valid (state_out_vld = 0).
REQ-024 flush = 1 SHALL, on the next edge, force FSM to COLLECT, word counter 0, round counter 0, state_out_vld 0; flush overrides word acceptance and state_out_rdy in the same cycle; state_out data is not cleared.
REQ-025 state_out_last SHALL equal state_out_vld && (state_out_rnd == LAST_ROUND).

Reset
REQ-026 With rst_n low at a rising edge: FSM = COLLECT, word counter = 0, round counter = 0, state_out = 0, state_out_vld = 0, state_out_rnd = 0, state_out_last = 0.
REQ-027 Reset asserted mid-block or in HOLD SHALL discard partial/held data with the values of REQ-026; it has priority over flush and all handshakes.

Verification
REQ-028 Reset, then words 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF on 4 consecutive cycles -> next cycle state_out = 0x00112233_44556677_8899AABB_CCDDEEFF, vld = 1, rnd = 0, word_in_rdy = 0.
REQ-029 Hold state_out_rdy = 0 for 5 cycles while word_in_vld = 1 with 0xDEADBEEF -> state_out unchanged, no word captured; then rdy = 1 -> vld drops next cycle, rnd becomes 1.
REQ-030 Eleven full blocks with state_out_rdy tied 1 -> rnd sequence 0..10, state_out_last = 1 only on the 11th, 12th block reports rnd = 0.
REQ-031 Flush after 2 words of a block at rnd = 3 -> next block needs 4 fresh words, reports rnd = 0, column 0 holds the first post-flush word.
REQ-032 rst_n low for one cycle while in HOLD with rnd = 5 -> state_out = 0, vld = 0, rnd = 0, word_in_rdy = 1 the cycle after rst_n returns high.
REQ-033 Gapped input: word_in_vld toggling 1/0 across 8 cycles -> exactly 4 words captured in order, vld rises one cycle after the 4th.
